// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared types and constants for the CAVLC coefficient scanner
// and the downstream encoder.
//   cavlc_mode_e  : block mode (4x4 luma, AC, 2x2 chroma DC)
//   scan_state_e  : scanner FSM state
//   ZIGZAG4x4     : 4x4 zig-zag scan index -> raster slot
//   scan_start/scan_end : first/last scan index walked per mode
package cavlc_pkg;

  localparam int MAX_COEF = 16;
  localparam int RUN_W    = 4;

  typedef enum logic [1:0] {
    MODE_4X4 = 2'd0,
    MODE_AC  = 2'd1,
    MODE_CDC = 2'd2
  } cavlc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam logic [3:0] ZIGZAG4x4 [MAX_COEF] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  // Scan walks from the start index down to the end index.
  localparam logic [3:0] SCAN_START_4X4 = 4'd15;
  localparam logic [3:0] SCAN_END_4X4   = 4'd0;
  localparam logic [3:0] SCAN_START_AC  = 4'd15;
  localparam logic [3:0] SCAN_END_AC    = 4'd1;
  localparam logic [3:0] SCAN_START_CDC = 4'd3;
  localparam logic [3:0] SCAN_END_CDC   = 4'd0;

  // Raw 2-bit mode code 3 behaves like 4x4.
  function automatic cavlc_mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_AC;
      2'd2:    return MODE_CDC;
      default: return MODE_4X4;
    endcase
  endfunction

  function automatic logic [3:0] scan_start(input cavlc_mode_e m);
    case (m)
      MODE_AC:  return SCAN_START_AC;
      MODE_CDC: return SCAN_START_CDC;
      default:  return SCAN_START_4X4;
    endcase
  endfunction

  function automatic logic [3:0] scan_end(input cavlc_mode_e m);
    case (m)
      MODE_AC:  return SCAN_END_AC;
      MODE_CDC: return SCAN_END_CDC;
      default:  return SCAN_END_4X4;
    endcase
  endfunction

endpackage

// File: rtl/cavlc_coeff_scanner_if.sv
// cavlc_coeff_scanner_if: block input and result output of the scanner.
//   in_*  : one coefficient block (raster order) plus mode and x/y tags
//   out_* : CAVLC counts, level list, run_before list, captured mode/tags
//   slave modport  : the scanner
//   master modport : the block producer / result consumer
// Handshake (both sides): a transfer happens on the rising clk edge where
// valid and ready are both high; the valid side holds its payload stable
// from the cycle valid rises until that edge, and ready never waits on a
// transfer that has not happened yet.
interface cavlc_coeff_scanner_if #(
  parameter int COEF_W = 15,
  parameter int TAG_W  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [16*COEF_W-1:0]  in_coef;
  logic [TAG_W-1:0]      in_tag_x;
  logic [TAG_W-1:0]      in_tag_y;

  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_mode;
  logic [4:0]            out_total_coeff;
  logic [1:0]            out_trailing_ones;
  logic [2:0]            out_t1_sign;
  logic [4:0]            out_total_zeros;
  logic [16*COEF_W-1:0]  out_level;
  logic [16*4-1:0]       out_run;
  logic [TAG_W-1:0]      out_tag_x;
  logic [TAG_W-1:0]      out_tag_y;

  modport slave (
    input  in_valid, in_mode, in_coef, in_tag_x, in_tag_y, out_ready,
    output in_ready, out_valid, out_mode, out_total_coeff, out_trailing_ones,
           out_t1_sign, out_total_zeros, out_level, out_run, out_tag_x, out_tag_y
  );

  modport master (
    output in_valid, in_mode, in_coef, in_tag_x, in_tag_y, out_ready,
    input  in_ready, out_valid, out_mode, out_total_coeff, out_trailing_ones,
           out_t1_sign, out_total_zeros, out_level, out_run, out_tag_x, out_tag_y
  );
endinterface

// File: rtl/cavlc_scan_addr.sv
// cavlc_scan_addr: combinational scan-index -> raster-slot map.
//   mode   : raw 2-bit block mode (3 behaves like 4x4)
//   idx    : current scan index
//   raster : raster slot holding that scan position
//   last   : idx is the lowest scan index walked for this mode
module cavlc_scan_addr
  import cavlc_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] idx,
  output logic [3:0] raster,
  output logic       last
);

  cavlc_mode_e m;
  assign m = to_mode(mode);

  always_comb begin
    raster = ZIGZAG4x4[idx];
    last   = (idx == scan_end(m));
    // 2x2 chroma DC is scanned in plain raster order.
    if (m == MODE_CDC) raster = idx;
  end

endmodule

// File: rtl/cavlc_coeff_scanner.sv
// cavlc_coeff_scanner: serial reverse-scan CAVLC count stage.
// Accepts one coefficient block per input handshake, walks it from the
// highest-frequency scan position down (one coefficient per clock) and
// presents total_coeff, trailing ones and signs, total_zeros, the level
// list and the run_before list until the output handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : cavlc_coeff_scanner_if.slave (block in, results out)
//   state_dbg : current FSM state
// Optional build macro CAVLC_STATS_EN adds stat_blocks / stat_zero_blocks
// (16-bit wrapping counts of delivered blocks and all-zero blocks).
module cavlc_coeff_scanner
  import cavlc_pkg::*;
#(
  parameter int COEF_W = 15,
  parameter int TAG_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  cavlc_coeff_scanner_if.slave   bus,
  output scan_state_e            state_dbg
`ifdef CAVLC_STATS_EN
  ,
  output logic [15:0]            stat_blocks,
  output logic [15:0]            stat_zero_blocks
`endif
);

  scan_state_e state_q, state_d;

  logic [MAX_COEF-1:0][COEF_W-1:0] coef_q;
  logic [MAX_COEF-1:0][COEF_W-1:0] level_q;
  logic [MAX_COEF-1:0][RUN_W-1:0]  run_q;
  logic [1:0]       mode_q;
  logic [TAG_W-1:0] tag_x_q, tag_y_q;
  logic [3:0]       idx_q;
  logic [4:0]       tc_q, tz_q;
  logic [1:0]       t1_q;
  logic [2:0]       t1_sign_q;
  logic             t1_frozen_q;  // set once a |v|>1 nonzero is seen

  logic [3:0]        raster;
  logic              last;
  logic [COEF_W-1:0] cur;
  logic              cur_nz, cur_pm1;
  logic [3:0]        run_slot;
  logic              accept, out_fire;

  cavlc_scan_addr u_addr (
    .mode   (mode_q),
    .idx    (idx_q),
    .raster (raster),
    .last   (last)
  );

  assign cur      = coef_q[raster];
  assign cur_nz   = |cur;
  assign cur_pm1  = (cur == COEF_W'(1)) || (&cur);
  // Run slot of the most recently seen nonzero.
  assign run_slot = tc_q[3:0] - 4'd1;

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign state_dbg     = state_q;

  assign bus.out_mode          = mode_q;
  assign bus.out_total_coeff   = tc_q;
  assign bus.out_trailing_ones = t1_q;
  assign bus.out_t1_sign       = t1_sign_q;
  assign bus.out_total_zeros   = tz_q;
  assign bus.out_level         = level_q;
  assign bus.out_run           = run_q;
  assign bus.out_tag_x         = tag_x_q;
  assign bus.out_tag_y         = tag_y_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_SCAN;
      ST_SCAN: if (last)     state_d = ST_DONE;
      ST_DONE: if (out_fire) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      coef_q      <= '0;
      level_q     <= '0;
      run_q       <= '0;
      mode_q      <= '0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
      idx_q       <= '0;
      tc_q        <= '0;
      tz_q        <= '0;
      t1_q        <= '0;
      t1_sign_q   <= '0;
      t1_frozen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            coef_q      <= bus.in_coef;
            mode_q      <= bus.in_mode;
            tag_x_q     <= bus.in_tag_x;
            tag_y_q     <= bus.in_tag_y;
            idx_q       <= scan_start(to_mode(bus.in_mode));
            level_q     <= '0;
            run_q       <= '0;
            tc_q        <= '0;
            tz_q        <= '0;
            t1_q        <= '0;
            t1_sign_q   <= '0;
            t1_frozen_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          idx_q <= idx_q - 4'd1;
          if (cur_nz) begin
            level_q[tc_q[3:0]] <= cur;
            tc_q               <= tc_q + 5'd1;
            if (!t1_frozen_q) begin
              if (cur_pm1) begin
                if (t1_q != 2'd3) begin
                  t1_sign_q <= t1_sign_q | (3'(cur[COEF_W-1]) << t1_q);
                  t1_q      <= t1_q + 2'd1;
                end
              end else begin
                t1_frozen_q <= 1'b1;
              end
            end
          end else if (tc_q != 5'd0) begin
            // Zeros above the highest-frequency nonzero are not counted.
            if (tz_q != 5'd16) tz_q <= tz_q + 5'd1;
            if (run_q[run_slot] != '1) run_q[run_slot] <= run_q[run_slot] + RUN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CAVLC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_blocks      <= '0;
      stat_zero_blocks <= '0;
    end else if (out_fire) begin
      stat_blocks <= stat_blocks + 16'd1;
      if (tc_q == 5'd0) stat_zero_blocks <= stat_zero_blocks + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cavlc_coeff_scanner.sv
// tb_cavlc_coeff_scanner: directed and randomized bench for the CAVLC
// coefficient scanner, checked against a list-based reference model.
module tb_cavlc_coeff_scanner;
  import cavlc_pkg::*;

  localparam int COEF_W = 15;
  localparam int TAG_W  = 10;
  localparam int RES_W  = 2 + 5 + 2 + 3 + 5 + 16*COEF_W + 64 + 2*TAG_W;

  logic clk = 1'b0;
  logic rst;
  scan_state_e state_dbg;
`ifdef CAVLC_STATS_EN
  logic [15:0] stat_blocks, stat_zero_blocks;
`endif

  cavlc_coeff_scanner_if #(.COEF_W(COEF_W), .TAG_W(TAG_W)) bus ();

  cavlc_coeff_scanner #(.COEF_W(COEF_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef CAVLC_STATS_EN
    ,
    .stat_blocks      (stat_blocks),
    .stat_zero_blocks (stat_zero_blocks)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RES_W-1:0] exp_q[$];
  int               exp_len_q[$];
  int               exp_blocks = 0;
  int               exp_zero_blocks = 0;

  logic signed [COEF_W-1:0] blk [16];
  int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  logic [1:0]           e_mode;
  logic [4:0]           e_tc, e_tz;
  logic [1:0]           e_to;
  logic [2:0]           e_sg;
  logic [16*COEF_W-1:0] e_lv;
  logic [63:0]          e_rv;
  logic [TAG_W-1:0]     e_tx, e_ty;

  // ---------------- reference model ----------------
  // Lists the block in reverse scan order, keeps the nonzeros and counts the
  // zeros that follow each one; everything else is derived from those lists.
  task automatic model_push(input logic [1:0] mode, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty);
    int order[$];
    int nzq[$];
    int runq[$];
    logic [16*COEF_W-1:0] lv;
    logic [63:0] rv;
    logic [2:0] sg;
    int to;
    int tz;
    int v;
    case (mode)
      2'd1:    for (int s = 15; s >= 1; s--) order.push_back(zz[s]);
      2'd2:    for (int r = 3; r >= 0; r--) order.push_back(r);
      default: for (int s = 15; s >= 0; s--) order.push_back(zz[s]);
    endcase
    foreach (order[i]) begin
      v = int'(blk[order[i]]);
      if (v != 0) begin
        nzq.push_back(v);
        runq.push_back(0);
      end else if (nzq.size() > 0) begin
        runq[runq.size()-1] = runq[runq.size()-1] + 1;
      end
    end
    lv = '0; rv = '0; tz = 0;
    foreach (nzq[k]) begin
      lv[k*COEF_W +: COEF_W] = COEF_W'(nzq[k]);
      rv[k*4 +: 4] = 4'(runq[k]);
      tz += runq[k];
    end
    to = 0; sg = '0;
    for (int k = 0; k < nzq.size() && k < 3; k++) begin
      if (nzq[k] == 1 || nzq[k] == -1) begin
        if (nzq[k] < 0) sg[k] = 1'b1;
        to++;
      end else break;
    end
    exp_q.push_back({mode, 5'(nzq.size()), 2'(to), sg, 5'(tz), lv, rv, tx, ty});
    exp_len_q.push_back(mode == 2'd1 ? 15 : (mode == 2'd2 ? 4 : 16));
  endtask

  function automatic logic [COEF_W-1:0] rand_coef(input int density);
    logic [COEF_W-1:0] c;
    int r;
    if ($urandom_range(0, 99) >= density) return '0;
    r = $urandom_range(0, 7);
    if (r <= 3)      c = COEF_W'(1);
    else if (r <= 5) c = COEF_W'($urandom_range(2, 5));
    else if (r == 6) c = COEF_W'($urandom);
    else             c = {1'b1, {(COEF_W-1){1'b0}}};
    if (r != 7 && $urandom_range(0, 1) == 1) c = -c;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_block(input logic [1:0] mode, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_tag_x = tx;
    bus.in_tag_y = ty;
    for (int i = 0; i < 16; i++) bus.in_coef[i*COEF_W +: COEF_W] = blk[i];
  endtask

  task automatic present(input string name, input logic [1:0] mode, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty);
    bit got;
    model_push(mode, tx, ty);
    drive_block(mode, tx, ty);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.in_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s accept: in_ready got 0 want 1 within 50 cycles", name); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int got;
    got = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin got = c; break; end
    end
    n_tests++;
    if (got != exp_len_q[0]) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles want %0d", name, got, exp_len_q[0]);
    end
  endtask

  task automatic check_out(input string name);
    {e_mode, e_tc, e_to, e_sg, e_tz, e_lv, e_rv, e_tx, e_ty} = exp_q[0];
    n_tests += 10;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL %s out_valid got %b want 1", name, bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready in DONE got %b want 0", name, bus.in_ready); end
    if (bus.out_mode !== e_mode) begin n_fail++; $display("FAIL %s mode got %0d want %0d", name, bus.out_mode, e_mode); end
    if (bus.out_total_coeff !== e_tc) begin n_fail++; $display("FAIL %s total_coeff got %0d want %0d", name, bus.out_total_coeff, e_tc); end
    if (bus.out_trailing_ones !== e_to) begin n_fail++; $display("FAIL %s trailing_ones got %0d want %0d", name, bus.out_trailing_ones, e_to); end
    if (bus.out_t1_sign !== e_sg) begin n_fail++; $display("FAIL %s t1_sign got %b want %b", name, bus.out_t1_sign, e_sg); end
    if (bus.out_total_zeros !== e_tz) begin n_fail++; $display("FAIL %s total_zeros got %0d want %0d", name, bus.out_total_zeros, e_tz); end
    if (bus.out_level !== e_lv) begin n_fail++; $display("FAIL %s level got %h want %h", name, bus.out_level, e_lv); end
    if (bus.out_run !== e_rv) begin n_fail++; $display("FAIL %s run got %h want %h", name, bus.out_run, e_rv); end
    if ({bus.out_tag_x, bus.out_tag_y} !== {e_tx, e_ty}) begin
      n_fail++; $display("FAIL %s tags got %0d,%0d want %0d,%0d", name, bus.out_tag_x, bus.out_tag_y, e_tx, e_ty);
    end
  endtask

  task automatic release_out(input string name);
    {e_mode, e_tc, e_to, e_sg, e_tz, e_lv, e_rv, e_tx, e_ty} = exp_q.pop_front();
    void'(exp_len_q.pop_front());
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_blocks++;
    if (e_tc == 5'd0) exp_zero_blocks++;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s out_valid after handshake got %b want 0", name, bus.out_valid); end
  endtask

  task automatic run_block(input string name, input logic [1:0] mode, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty);
    present(name, mode, tx, ty);
    wait_out(name);
    check_out(name);
    release_out(name);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 16; i++) blk[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_coef = '0;
    bus.in_tag_x = '0; bus.in_tag_y = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests += 3;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    if ({bus.out_total_coeff, bus.out_total_zeros, bus.out_level, bus.out_run, bus.out_tag_x} !== '0) begin
      n_fail++; $display("FAIL reset outputs got tc=%0d tz=%0d level=%h want all 0", bus.out_total_coeff, bus.out_total_zeros, bus.out_level);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    int v1 [9] = '{0, 3, -1, 0, 0, -1, 1, 0, 1};
    // 4x4 example block, with the literal expected counts as well.
    clear_blk();
    for (int s = 0; s < 9; s++) blk[zz[s]] = COEF_W'(v1[s]);
    present("vec_4x4", 2'd0, 10'd3, 10'd7);
    wait_out("vec_4x4");
    n_tests += 3;
    if (bus.out_total_coeff !== 5'd5 || bus.out_trailing_ones !== 2'd3) begin
      n_fail++; $display("FAIL vec_4x4 literal counts got tc=%0d t1=%0d want 5,3", bus.out_total_coeff, bus.out_trailing_ones);
    end
    if (bus.out_t1_sign !== 3'b100 || bus.out_total_zeros !== 5'd4) begin
      n_fail++; $display("FAIL vec_4x4 literal sign/zeros got %b,%0d want 100,4", bus.out_t1_sign, bus.out_total_zeros);
    end
    if (bus.out_run[19:0] !== {4'd1, 4'd0, 4'd2, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL vec_4x4 literal runs got %h want 10201", bus.out_run[19:0]);
    end
    check_out("vec_4x4");
    release_out("vec_4x4");

    clear_blk();
    run_block("vec_zero", 2'd0, 10'd0, 10'd0);

    clear_blk();
    blk[0] = COEF_W'(7); blk[15] = COEF_W'(-1);
    run_block("vec_ac", 2'd1, 10'd1023, 10'd512);

    clear_blk();
    blk[0] = COEF_W'(5); blk[2] = COEF_W'(-1); blk[3] = COEF_W'(1);
    present("vec_cdc", 2'd2, 10'd5, 10'd9);
    wait_out("vec_cdc");
    n_tests++;
    if (bus.out_level[3*COEF_W-1:0] !== {COEF_W'(5), COEF_W'(-1), COEF_W'(1)} || bus.out_t1_sign !== 3'b010) begin
      n_fail++; $display("FAIL vec_cdc literal levels got %h sign %b want 1,-1,5 / 010", bus.out_level[3*COEF_W-1:0], bus.out_t1_sign);
    end
    check_out("vec_cdc");
    release_out("vec_cdc");

    // Full block of -1: trailing ones stop at 3, every slot used.
    for (int i = 0; i < 16; i++) blk[i] = COEF_W'(-1);
    run_block("vec_full", 2'd3, 10'd2, 10'd2);
  endtask

  task automatic test_random();
    int density;
    for (int n = 0; n < 40; n++) begin
      density = $urandom_range(5, 90);
      for (int i = 0; i < 16; i++) blk[i] = rand_coef(density);
      present("random", 2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom));
      wait_out("random");
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      check_out("random");
      release_out("random");
    end
  endtask

  task automatic test_backpressure();
    clear_blk();
    blk[4] = COEF_W'(-2); blk[11] = COEF_W'(1);
    present("bp_a", 2'd0, 10'd11, 10'd12);
    wait_out("bp_a");
    clear_blk();
    blk[1] = COEF_W'(1); blk[3] = COEF_W'(9);
    model_push(2'd2, 10'd21, 10'd22);
    drive_block(2'd2, 10'd21, 10'd22);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_out("bp_hold");
    end
    release_out("bp_a");
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next accept in_ready got %b want 0", bus.in_ready); end
    wait_out("bp_b");
    check_out("bp_b");
    release_out("bp_b");
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 16; i++) blk[i] = COEF_W'($urandom_range(1, 3));
    present("rst_mid", 2'd0, 10'd44, 10'd55);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_len_q.delete();
    exp_blocks = 0;
    exp_zero_blocks = 0;
    n_tests += 3;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid handshake got valid=%b ready=%b want 0,0", bus.out_valid, bus.in_ready);
    end
    if ({bus.out_total_coeff, bus.out_trailing_ones, bus.out_t1_sign, bus.out_total_zeros} !== '0) begin
      n_fail++; $display("FAIL rst_mid counts got tc=%0d t1=%0d want 0", bus.out_total_coeff, bus.out_trailing_ones);
    end
    if ({bus.out_level, bus.out_run, bus.out_tag_x, bus.out_tag_y, bus.out_mode} !== '0) begin
      n_fail++; $display("FAIL rst_mid lists got level=%h run=%h want 0", bus.out_level, bus.out_run);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid release in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    clear_blk();
    blk[0] = COEF_W'(-3); blk[1] = COEF_W'(1); blk[2] = COEF_W'(1);
    run_block("rst_after", 2'd2, 10'd6, 10'd8);
  endtask

  task automatic test_stats();
`ifdef CAVLC_STATS_EN
    n_tests += 2;
    if (stat_blocks !== 16'(exp_blocks)) begin n_fail++; $display("FAIL stat_blocks got %0d want %0d", stat_blocks, exp_blocks); end
    if (stat_zero_blocks !== 16'(exp_zero_blocks)) begin
      n_fail++; $display("FAIL stat_zero_blocks got %0d want %0d", stat_zero_blocks, exp_zero_blocks);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stats();
    test_backpressure();
    test_random();
    test_reset_mid_scan();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_scanner.md
Name: cavlc_coeff_scanner

Overview:
Parametrised successor of the CAVLC count stage. Accepts one quantised coefficient block per handshake and extracts the CAVLC syntax counts, level list and run_before list for the downstream encoder. Supports three block modes: 4x4 luma (16 coeffs), AC (15 coeffs, DC skipped) and 2x2 chroma DC (4 coeffs). Uses a serial reverse-scan FSM, one coefficient per cycle, with valid/ready on both sides and a position tag carried through.

Parameters:
COEF_W, 15, signed coefficient width in bits (range 2..16)
TAG_W, 10, width of each block-position tag (x and y)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input block valid
in_ready  out  1  scanner can accept a block
in_mode  in  2  0=4x4, 1=AC, 2=chroma DC 2x2, 3=treated as 0
in_coef  in  16*COEF_W  raster-order coefficients; slot r = bits [r*COEF_W +: COEF_W]
in_tag_x  in  TAG_W  block x position
in_tag_y  in  TAG_W  block y position
out_valid  out  1  results valid
out_ready  in  1  encoder accepts results
out_mode  out  2  captured mode
out_total_coeff  out  5  nonzero count (0..16)
out_trailing_ones  out  2  trailing ±1 count (0..3)
out_t1_sign  out  3  bit k = sign of k-th trailing one, highest frequency first; 1 = negative
out_total_zeros  out  5  zeros below the last nonzero within the scan range
out_level  out  16*COEF_W  nonzero levels in reverse scan order; slot 0 = highest frequency
out_run  out  16*4  run_before per nonzero, same slot order
out_tag_x, out_tag_y  out  TAG_W  captured tags

Behaviour:
- Reset: all outputs 0; in_ready=0 while rst is high, then 1 in IDLE. FSM returns to IDLE from any state, and any in-flight block is discarded.
- States: IDLE (in_ready=1) -> accept on in_valid&in_ready; the edge captures coefficients, mode and tags and loads idx = top scan index -> SCAN -> DONE (out_valid=1) -> IDLE on out_valid&out_ready.
- Scan tables: 4x4 scan index->raster = 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - 4x4: scan 15..0.
  - AC: scan 15..1.
  - Chroma DC: raster slots 3..0.
- SCAN processes one coefficient per edge, from highest scan index down. SCAN length N = 16/15/4; out_valid rises N edges after the accept edge.
- Nonzero coefficient:
  - Written to out_level[total_coeff].
  - Its slot's run counter opens.
  - total_coeff increments.
- Trailing ones: while no |v|>1 nonzero has been seen and trailing_ones<3, each ±1 increments trailing_ones and records its sign. The first |v|>1 freezes the count.
- Zero coefficient: if total_coeff>0, increment total_zeros and out_run[total_coeff-1]. Zeros above the last nonzero are ignored.
- Run of the lowest-frequency nonzero: its preceding zeros are still counted into its slot. The encoder ignores that slot.
- Unused level and run slots are 0. Run counters saturate at 15, total_zeros at 16.
- total_coeff==0 (all-zero block): out_valid still asserts, all counts are 0, scan takes full N cycles.
- Level bits are copied unmodified (no saturation). Width arithmetic is in COEF_W signed.
- DONE holds all outputs stable until out_ready. No new accept occurs before the DONE handshake.
- out_valid and in_ready are never both high in the same cycle.

Optional Feature:
CAVLC_STATS_EN:
- Defined: adds outputs stat_blocks[15:0] and stat_zero_blocks[15:0].
  - Both are reset to 0.
  - stat_blocks increments on each out handshake.
  - stat_zero_blocks increments on each out handshake with total_coeff==0.
  - Both wrap at 16 bits.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cavlc_pkg:
  - cavlc_mode_e enum (MODE_4X4, MODE_AC, MODE_CDC)
  - ZIGZAG4x4 scan constant array
  - scan length/start constants per mode
  - MAX_COEF=16 and RUN_W=4
  - scanner FSM state enum
- One natural sub-module: cavlc_scan_addr. Maps (mode, idx) to the raster slot and flags the last index. It is combinational and reusable by the later encoder.

Test Plan:
- Mode 0, scan-order values 0,3,-1,0,0,-1,1,0,1,0x7 -> total_coeff=5, trailing_ones=3, t1_sign=3'b100, total_zeros=4, levels 1,1,-1,-1,3, runs 1,0,2,0,1; out_valid 16 cycles after accept.
- Mode 0, all zeros -> counts 0, all level/run slots 0, out_valid after 16 cycles. With CAVLC_STATS_EN, stat_zero_blocks=1.
- Mode 1, scan pos0=7 and pos15=-1, rest 0 -> pos0 ignored; total_coeff=1, trailing_ones=1, t1_sign=3'b001, total_zeros=14; out_valid after 15 cycles.
- Mode 2, raster 5,0,-1,1 -> total_coeff=3, trailing_ones=2, t1_sign=3'b010, levels 1,-1,5, total_zeros=1; out_valid after 4 cycles.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> outputs stable, in_ready=0. Release -> next block is accepted the cycle after the handshake.
- Assert rst mid-SCAN -> outputs 0 immediately. After release, in_ready=1 and the next block scans correctly.
